// File: rtl/fmpadding_pkg.sv
// Shared types and helpers for the feature-map padding config sequencer:
// config address map, geometry record and index/address conversions.
package fmpadding_pkg;

   localparam logic [4:0] ADDR_XON  = 5'd0;
   localparam logic [4:0] ADDR_XOFF = 5'd4;
   localparam logic [4:0] ADDR_XEND = 5'd8;
   localparam logic [4:0] ADDR_YON  = 5'd12;
   localparam logic [4:0] ADDR_YOFF = 5'd16;
   localparam logic [4:0] ADDR_YEND = 5'd20;

   localparam logic [2:0] IDX_YON   = 3'd3;
   localparam logic [2:0] IDX_LAST  = 3'd5;
   localparam logic [2:0] IDX_NONE  = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_WRITE} seq_state_e;

   typedef struct packed {
      logic [31:0] xon;
      logic [31:0] xoff;
      logic [31:0] xend;
      logic [31:0] yon;
      logic [31:0] yoff;
      logic [31:0] yend;
   } cfg_t;

   function automatic logic [4:0] idxToAddr(input logic [2:0] idx);
      case (idx)
         3'd0:    return ADDR_XON;
         3'd1:    return ADDR_XOFF;
         3'd2:    return ADDR_XEND;
         3'd3:    return ADDR_YON;
         3'd4:    return ADDR_YOFF;
         default: return ADDR_YEND;
      endcase
   endfunction

   // IDX_NONE flags an address outside the register map
   function automatic logic [2:0] addrToIdx(input logic [4:0] addr);
      case (addr)
         ADDR_XON:  return 3'd0;
         ADDR_XOFF: return 3'd1;
         ADDR_XEND: return 3'd2;
         ADDR_YON:  return 3'd3;
         ADDR_YOFF: return 3'd4;
         ADDR_YEND: return 3'd5;
         default:   return IDX_NONE;
      endcase
   endfunction

   function automatic logic [31:0] getField(input cfg_t c, input logic [2:0] idx);
      case (idx)
         3'd0:    return c.xon;
         3'd1:    return c.xoff;
         3'd2:    return c.xend;
         3'd3:    return c.yon;
         3'd4:    return c.yoff;
         default: return c.yend;
      endcase
   endfunction

   function automatic cfg_t setField(input cfg_t c, input logic [2:0] idx, input logic [31:0] v);
      cfg_t r;
      r = c;
      case (idx)
         3'd0:    r.xon  = v;
         3'd1:    r.xoff = v;
         3'd2:    r.xend = v;
         3'd3:    r.yon  = v;
         3'd4:    r.yoff = v;
         3'd5:    r.yend = v;
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fmpadding_cfg_sequencer_if.sv
// Host config, padding config port and gated output handshake of the sequencer.
interface fmpadding_cfg_sequencer_if;
   logic        cfg_we;
   logic [4:0]  cfg_wa;
   logic [31:0] cfg_wd;
   logic        cfg_commit;
   logic        cfg_busy;
   logic        cfg_done;
   logic        pad_we;
   logic [4:0]  pad_wa;
   logic [31:0] pad_wd;
   logic        pad_tvalid;
   logic        pad_tready;
   logic        dn_tready;
   logic        dn_tvalid;

   modport slave (
      input  cfg_we, cfg_wa, cfg_wd, cfg_commit, pad_tvalid, dn_tready,
      output cfg_busy, cfg_done, pad_we, pad_wa, pad_wd, pad_tready, dn_tvalid
   );

   modport master (
      output cfg_we, cfg_wa, cfg_wd, cfg_commit, pad_tvalid, dn_tready,
      input  cfg_busy, cfg_done, pad_we, pad_wa, pad_wd, pad_tready, dn_tvalid
   );
endinterface

// File: rtl/fmpadding_pos_tracker.sv
// Mirrors the S/X/Y frame position of the beat sitting in a stream output register.
// Geometry is sampled at each frame boundary so a frame always ends under its own geometry.
module fmpadding_pos_tracker #(
   parameter int SF        = 1,
   parameter int XBITS     = 8,
   parameter int YBITS     = 8,
   parameter int INIT_XEND = 1,
   parameter int INIT_YEND = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             beat_i,
   input  logic [XBITS-1:0] xend_i,
   input  logic [YBITS-1:0] yend_i,
   output logic             last_o
);

   localparam int SW = $clog2(SF) + 1;
   localparam logic [SW-1:0] S_RELOAD = SW'(SF - 1);

   logic [SW-1:0]    s_q, s_d;
   logic [XBITS-1:0] x_q, x_d, geoXend_q, geoXend_d;
   logic [YBITS-1:0] y_q, y_d, geoYend_q, geoYend_d;
   logic             sWrap, xWrap, yWrap;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q       <= S_RELOAD;
         x_q       <= '0;
         y_q       <= '0;
         geoXend_q <= XBITS'(INIT_XEND);
         geoYend_q <= YBITS'(INIT_YEND);
      end else begin
         s_q       <= s_d;
         x_q       <= x_d;
         y_q       <= y_d;
         geoXend_q <= geoXend_d;
         geoYend_q <= geoYend_d;
      end
   end

   always_comb begin
      sWrap     = (s_q == '0);
      xWrap     = (x_q == geoXend_q);
      yWrap     = (y_q == geoYend_q);
      last_o    = sWrap && xWrap && yWrap;
      s_d       = s_q;
      x_d       = x_q;
      y_d       = y_q;
      geoXend_d = geoXend_q;
      geoYend_d = geoYend_q;
      if (beat_i) begin
         s_d = sWrap ? S_RELOAD : s_q - SW'(1);
         if (sWrap) begin
            x_d = xWrap ? '0 : x_q + XBITS'(1);
            if (xWrap) y_d = yWrap ? '0 : y_q + YBITS'(1);
         end
         if (last_o) begin
            geoXend_d = xend_i;
            geoYend_d = yend_i;
         end
      end
   end

endmodule

// File: rtl/fmpadding_cfg_sequencer.sv
// Frame-synchronous reconfiguration of the padding block: stalls the last beat of a
// frame, replays the six shadow registers into the padding config port, then releases it.
module fmpadding_cfg_sequencer
   import fmpadding_pkg::*;
#(
   parameter int XCOUNTER_BITS = 8,
   parameter int YCOUNTER_BITS = 8,
   parameter int NUM_CHANNELS  = 1,
   parameter int SIMD          = 1,
   parameter int INIT_XON      = 0,
   parameter int INIT_XOFF     = 1,
   parameter int INIT_XEND     = 1,
   parameter int INIT_YON      = 0,
   parameter int INIT_YOFF     = 1,
   parameter int INIT_YEND     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   fmpadding_cfg_sequencer_if.slave  bus
);

   localparam int SF = NUM_CHANNELS / SIMD;
   localparam logic [31:0] XMASK = (XCOUNTER_BITS >= 32) ? 32'hFFFF_FFFF
                                   : 32'((64'd1 << XCOUNTER_BITS) - 64'd1);
   localparam logic [31:0] YMASK = (YCOUNTER_BITS >= 32) ? 32'hFFFF_FFFF
                                   : 32'((64'd1 << YCOUNTER_BITS) - 64'd1);
   localparam cfg_t INIT_CFG = '{xon: 32'(INIT_XON), xoff: 32'(INIT_XOFF), xend: 32'(INIT_XEND),
                                 yon: 32'(INIT_YON), yoff: 32'(INIT_YOFF), yend: 32'(INIT_YEND)};

   seq_state_e               state_q, state_d;
   logic [2:0]               widx_q, widx_d;
   cfg_t                     shadow_q, shadow_d;
   logic [XCOUNTER_BITS-1:0] actXend_q, actXend_d;
   logic [YCOUNTER_BITS-1:0] actYend_q, actYend_d;
   logic                     done_q, done_d;
   logic [2:0]               wrIdx;
   logic                     last, hold, beat;

   fmpadding_pos_tracker #(
      .SF(SF), .XBITS(XCOUNTER_BITS), .YBITS(YCOUNTER_BITS),
      .INIT_XEND(INIT_XEND), .INIT_YEND(INIT_YEND)
   ) u_pos (
      .clk(clk), .rst(rst), .beat_i(beat),
      .xend_i(actXend_q), .yend_i(actYend_q), .last_o(last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         widx_q    <= '0;
         shadow_q  <= INIT_CFG;
         actXend_q <= XCOUNTER_BITS'(INIT_XEND);
         actYend_q <= YCOUNTER_BITS'(INIT_YEND);
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         widx_q    <= widx_d;
         shadow_q  <= shadow_d;
         actXend_q <= actXend_d;
         actYend_q <= actYend_d;
         done_q    <= done_d;
      end
   end

   // Hold is combinational so the last beat never slips out in the cycle it is detected
   always_comb begin
      hold = ((state_q == ST_ARMED) && bus.pad_tvalid && last) || (state_q == ST_WRITE);
      beat = bus.pad_tvalid && bus.pad_tready;
      bus.pad_tready = bus.dn_tready && !hold;
      bus.dn_tvalid  = bus.pad_tvalid && !hold;
      bus.cfg_busy   = (state_q != ST_IDLE);
      bus.cfg_done   = done_q;
      bus.pad_we     = (state_q == ST_WRITE);
      bus.pad_wa     = bus.pad_we ? idxToAddr(widx_q) : '0;
      bus.pad_wd     = bus.pad_we ? getField(shadow_q, widx_q) : '0;
   end

   always_comb begin
      state_d   = state_q;
      widx_d    = widx_q;
      shadow_d  = shadow_q;
      actXend_d = actXend_q;
      actYend_d = actYend_q;
      done_d    = 1'b0;
      wrIdx     = addrToIdx(bus.cfg_wa);
      if (bus.cfg_we && (state_q == ST_IDLE) && (wrIdx != IDX_NONE))
         shadow_d = setField(shadow_q, wrIdx,
                             bus.cfg_wd & ((wrIdx < IDX_YON) ? XMASK : YMASK));
      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_commit) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (bus.pad_tvalid && last) begin
               state_d = ST_WRITE;
               widx_d  = '0;
            end
         end
         ST_WRITE: begin
            if (widx_q == 3'd2) actXend_d = shadow_q.xend[XCOUNTER_BITS-1:0];
            if (widx_q == IDX_LAST) begin
               actYend_d = shadow_q.yend[YCOUNTER_BITS-1:0];
               state_d   = ST_IDLE;
               done_d    = 1'b1;
            end else begin
               widx_d = widx_q + 3'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
